// File: rtl/regwr_scheduler.sv
// Register-file writeback scheduler: arbitrates ALU and load writebacks onto one
// registered write port and keeps a pending-write scoreboard for issue and hazard checks.
module regwr_scheduler #(
  parameter int FAIR = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        iss_ready,
  input  logic [4:0]  rs,
  input  logic [4:0]  rs2,
  output logic        haz_a,
  output logic        haz_b,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_wr,
  output logic        wb_rtype,
  output logic [31:0] pending
);

  logic        last_ld;
  logic [31:0] pend_p1;
  logic        vld_p1;
  logic [4:0]  rd_p1;
  logic [31:0] data_p1;

  logic        gnt_alu;
  logic        gnt_ld;
  logic        gnt;
  logic        wr_en;
  logic [4:0]  gnt_rd;
  logic [31:0] gnt_data;
  logic        iss_set;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  // Readies stay low while reset is held so nothing is accepted during reset.
  always_comb begin
    gnt_alu = 1'b0;
    gnt_ld  = 1'b0;
    if (reset) begin
      if (alu_valid && ld_valid) begin
        if ((FAIR != 0) && last_ld) gnt_alu = 1'b1;
        else                        gnt_ld  = 1'b1;
      end else begin
        gnt_alu = alu_valid;
        gnt_ld  = ld_valid;
      end
    end
  end

  assign gnt      = gnt_alu | gnt_ld;
  assign gnt_rd   = gnt_ld ? ld_rd : alu_rd;
  assign gnt_data = gnt_ld ? ld_data : alu_data;
  assign wr_en    = gnt && (gnt_rd != 5'd0);

  // No same-cycle bypass: a WAW claim waits for the bit to clear on a prior edge.
  assign iss_ready = reset && ((iss_rd == 5'd0) || !pend_p1[iss_rd]);
  assign iss_set   = iss_valid && iss_ready && (iss_rd != 5'd0);

  assign set_mask = iss_set ? (32'd1 << iss_rd) : 32'd0;
  assign clr_mask = wr_en   ? (32'd1 << gnt_rd) : 32'd0;

  // Grant edge -> write port stage (p1)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_p1 <= 32'd0;
      last_ld <= 1'b1;
      vld_p1  <= 1'b0;
      rd_p1   <= 5'd0;
      data_p1 <= 32'd0;
    end else begin
      pend_p1 <= (pend_p1 & ~clr_mask) | set_mask;
      vld_p1  <= wr_en;
      if (gnt) last_ld <= gnt_ld;
      if (wr_en) begin
        rd_p1   <= gnt_rd;
        data_p1 <= gnt_data;
      end
    end
  end

  assign alu_ready = gnt_alu;
  assign ld_ready  = gnt_ld;
  assign haz_a     = (rs  != 5'd0) && pend_p1[rs];
  assign haz_b     = (rs2 != 5'd0) && pend_p1[rs2];
  assign wb_wr     = vld_p1;
  assign wb_rd     = rd_p1;
  assign wb_data   = data_p1;
  assign wb_rtype  = 1'b1;
  assign pending   = pend_p1;

endmodule

// File: tb/tb_regwr_scheduler.sv
// Randomized bench for regwr_scheduler against a cycle-level reference model,
// plus a second fixed-priority instance exercised with a short directed sequence.
module tb_regwr_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, ld_valid, iss_valid;
  logic [4:0]  alu_rd, ld_rd, iss_rd, rs, rs2;
  logic [31:0] alu_data, ld_data;
  logic        alu_ready, ld_ready, iss_ready, haz_a, haz_b, wb_wr, wb_rtype;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, pending;

  logic        fx_av, fx_lv;
  logic [4:0]  fx_ard, fx_lrd;
  logic [31:0] fx_adat, fx_ldat;
  logic        fx_alu_ready, fx_ld_ready, fx_iss_ready, fx_haz_a, fx_haz_b, fx_wb_wr, fx_wb_rtype;
  logic [4:0]  fx_wb_rd;
  logic [31:0] fx_wb_data, fx_pending;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regwr_scheduler #(.FAIR(1)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs(rs), .rs2(rs2), .haz_a(haz_a), .haz_b(haz_b),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_wr(wb_wr), .wb_rtype(wb_rtype), .pending(pending)
  );

  regwr_scheduler #(.FAIR(0)) dut_fx (
    .clk(clk), .reset(reset),
    .alu_valid(fx_av), .alu_rd(fx_ard), .alu_data(fx_adat), .alu_ready(fx_alu_ready),
    .ld_valid(fx_lv), .ld_rd(fx_lrd), .ld_data(fx_ldat), .ld_ready(fx_ld_ready),
    .iss_valid(1'b0), .iss_rd(5'd0), .iss_ready(fx_iss_ready),
    .rs(5'd0), .rs2(5'd0), .haz_a(fx_haz_a), .haz_b(fx_haz_b),
    .wb_rd(fx_wb_rd), .wb_data(fx_wb_data), .wb_wr(fx_wb_wr), .wb_rtype(fx_wb_rtype),
    .pending(fx_pending)
  );

  // Reference model state
  bit          m_pend [32];
  bit          m_last_ld;
  bit          m_wr;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          acc_alu, acc_ld, acc_iss;
  logic        obs_alu;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_last_ld = 1'b1;
    m_wr = 1'b0;
    m_rd = 5'd0;
    m_data = 32'd0;
    acc_alu = 1'b0;
    acc_ld = 1'b0;
    acc_iss = 1'b0;
  endtask

  // One clock cycle: check registered state, drive, check combinational, advance the model.
  task automatic cycle(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ldat,
                       input bit iv, input logic [4:0] ird,
                       input logic [4:0] r1, input logic [4:0] r2);
    bit ga, gl, gi;
    logic [4:0] wrd;
    @(negedge clk);
    check("wb_wr", wb_wr, m_wr);
    check("wb_rd", wb_rd, m_rd);
    check("wb_data", wb_data, m_data);
    check("pending", pending, pend_vec());
    check("wb_rtype", wb_rtype, 1);
    alu_valid = av; alu_rd = ard; alu_data = adat;
    ld_valid = lv;  ld_rd = lrd;  ld_data = ldat;
    iss_valid = iv; iss_rd = ird; rs = r1; rs2 = r2;
    #1;
    if (av && lv) begin
      ga = m_last_ld;
      gl = !m_last_ld;
    end else begin
      ga = av;
      gl = lv;
    end
    gi = (ird == 5'd0) || !m_pend[ird];
    check("alu_ready", alu_ready, ga);
    check("ld_ready", ld_ready, gl);
    check("iss_ready", iss_ready, gi);
    check("haz_a", haz_a, (r1 != 0) && m_pend[r1]);
    check("haz_b", haz_b, (r2 != 0) && m_pend[r2]);
    obs_alu = alu_ready;
    acc_alu = ga;
    acc_ld = gl;
    acc_iss = iv && gi;
    @(posedge clk);
    m_wr = 1'b0;
    if (ga || gl) begin
      m_last_ld = gl;
      wrd = gl ? lrd : ard;
      if (wrd != 5'd0) begin
        m_wr = 1'b1;
        m_rd = wrd;
        m_data = gl ? ldat : adat;
        m_pend[wrd] = 1'b0;
      end
    end
    if (iv && gi && ird != 5'd0) m_pend[ird] = 1'b1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset pulse placed between edges; effects must appear without a clock.
  task automatic reset_pulse(input string tag);
    #2;
    reset = 1'b0;
    #1;
    check({tag, "_wb_wr"}, wb_wr, 0);
    check({tag, "_wb_rd"}, wb_rd, 0);
    check({tag, "_wb_data"}, wb_data, 0);
    check({tag, "_pending"}, pending, 0);
    check({tag, "_readies"}, {alu_ready, ld_ready, iss_ready}, 0);
    model_reset();
    alu_valid = 0; ld_valid = 0; iss_valid = 0;
    fx_av = 0; fx_lv = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bit av, lv, iv;
    logic [4:0] ard, lrd, ird;
    logic [31:0] adat, ldat;

    reset = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    iss_valid = 0; iss_rd = 0; rs = 0; rs2 = 0;
    fx_av = 0; fx_ard = 0; fx_adat = 0; fx_lv = 0; fx_lrd = 0; fx_ldat = 0;
    model_reset();

    // Reset state, with requests presented that must not be accepted
    repeat (2) @(posedge clk);
    @(negedge clk);
    alu_valid = 1; ld_valid = 1; iss_valid = 1; iss_rd = 5'd3;
    #1;
    check("rst_alu_ready", alu_ready, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_iss_ready", iss_ready, 0);
    check("rst_wb_wr", wb_wr, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_pending", pending, 0);
    alu_valid = 0; ld_valid = 0; iss_valid = 0; iss_rd = 0;
    reset = 1'b1;

    // Fixed-priority instance: load always wins a tie
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      fx_av = 1; fx_ard = 5'd3; fx_adat = 32'h55;
      fx_lv = 1; fx_lrd = 5'd4; fx_ldat = 32'h100 + i;
      #1;
      check("fx_ld_ready", fx_ld_ready, 1);
      check("fx_alu_ready", fx_alu_ready, 0);
      @(posedge clk);
    end
    @(negedge clk);
    check("fx_wb_rd_ld", fx_wb_rd, 4);
    check("fx_wb_data_ld", fx_wb_data, 32'h102);
    fx_lv = 0;
    #1;
    check("fx_alu_alone", fx_alu_ready, 1);
    @(posedge clk);
    @(negedge clk);
    fx_av = 0;
    check("fx_wb_rd_alu", fx_wb_rd, 3);
    check("fx_wb_data_alu", fx_wb_data, 32'h55);

    // Round-robin tie: ALU first, then alternate
    for (int i = 0; i < 4; i++) begin
      cycle(1, 5'd3, 32'hA0 + i, 1, 5'd4, 32'hB0 + i, 0, 0, 0, 0);
      check("rr_alu", obs_alu, (i % 2 == 0) ? 1 : 0);
    end
    idle();

    // Issue then ALU write of the same register
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 0);
    #1;
    check("t34_pend5_set", pending[5], 1);
    cycle(1, 5'd5, 32'h0000_00AA, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("t34_pend5_clr", pending[5], 0);
    check("t34_wb_wr", wb_wr, 1);
    check("t34_wb_rd", wb_rd, 5);
    check("t34_wb_data", wb_data, 32'hAA);

    // WAW stall on register 7 with a source hazard
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd7);
    check("t37_stall", acc_iss, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0);
    cycle(0, 0, 0, 1, 5'd7, 32'h77, 1, 5'd7, 5'd7, 0);
    check("t37_no_bypass", acc_iss, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0);
    check("t37_released", acc_iss, 1);
    cycle(1, 5'd7, 32'h78, 0, 0, 0, 0, 0, 5'd7, 0);

    // Register 0 writes and claims
    cycle(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 1, 5'd0, 0, 0);
    idle();

    // Set and clear of register 9 at one edge, then async reset mid-cycle
    cycle(1, 5'd9, 32'h99, 0, 0, 0, 1, 5'd9, 0, 0);
    #1;
    check("t39_pend9", pending[9], 1);
    check("t39_wr_before", wb_wr, 1);
    reset_pulse("t39");
    idle();

    // Randomized traffic obeying the hold-until-ready protocol
    av = 0; lv = 0; iv = 0;
    ard = 0; lrd = 0; ird = 0; adat = 0; ldat = 0;
    for (int c = 0; c < 600; c++) begin
      if (!av || acc_alu) begin
        av = ($urandom_range(0, 2) != 0);
        ard = 5'($urandom_range(0, 7));
        adat = $urandom;
      end
      if (!lv || acc_ld) begin
        lv = ($urandom_range(0, 2) != 0);
        lrd = 5'($urandom_range(0, 7));
        ldat = $urandom;
      end
      if (!iv || acc_iss) begin
        iv = ($urandom_range(0, 1) != 0);
        ird = 5'($urandom_range(0, 7));
      end
      cycle(av, ard, adat, lv, lrd, ldat, iv, ird,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      if (c == 300) begin
        reset_pulse("rand_rst");
        av = 0; lv = 0; iv = 0;
      end
    end
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regwr_scheduler.md
REGWR_SCHEDULER -- requirements
Module: regwr_scheduler

Interface
REQ-001 Parameter: FAIR, default 1; 1 = round-robin between write sources, 0 = load source has fixed priority.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately, independent of clk.
REQ-004 alu_valid  input  1  ALU writeback request.
REQ-005 alu_rd  input  5  ALU destination register.
REQ-006 alu_data  input  32  ALU result.
REQ-007 alu_ready  output  1  ALU request accepted this cycle.
REQ-008 ld_valid / ld_rd / ld_data  input  1/5/32  load writeback request, destination and data.
REQ-009 ld_ready  output  1  load request accepted this cycle.
REQ-010 iss_valid  input  1  instruction issue; claims destination iss_rd.
REQ-011 iss_rd  input  5  destination being claimed.
REQ-012 iss_ready  output  1  issue accepted this cycle.
REQ-013 rs / rs2  input  5/5  source register numbers being read from the register file.
REQ-014 haz_a / haz_b  output  1/1  source rs / rs2 has a write outstanding.
REQ-015 wb_rd / wb_data / wb_wr  output  5/32/1  registered write port to the register file (destination, busW, reg_wr).
REQ-016 wb_rtype  output  1  register-file destination select; constant 1 so writes use rd.
REQ-017 pending  output  32  scoreboard; bit i set = register i has an outstanding write.

Function
REQ-018 Handshake: a request transfers when its valid and ready are both 1 on a rising edge; a requester holds valid, rd and data stable until ready.
REQ-019 At most one of alu_ready and ld_ready SHALL be 1 in any cycle; ready is combinational from the valids and the arbitration state.
REQ-020 Single valid: that source is granted in the same cycle.
REQ-021 Both valid, FAIR=1: grant the source not granted most recently; a 1-bit last-grant register updates on every grant.
REQ-022 Both valid, FAIR=0: load is granted; ALU waits.
REQ-023 Write latency: a grant at edge N drives wb_wr=1, wb_rd and wb_data from the granted source during cycle N+1; with no grant, wb_wr=0 and wb_rd/wb_data hold their previous values.
REQ-024 Destination 0: the request is accepted (ready=1) but wb_wr stays 0; register 0 is never written.
REQ-025 Scoreboard set: an issue handshake with iss_rd != 0 sets pending[iss_rd] at the edge.
REQ-026 Scoreboard clear: a writeback grant with rd != 0 clears pending[rd] at the grant edge.
REQ-027 Same register set and cleared at the same edge: set wins.
REQ-028 iss_ready = 1 when iss_rd == 0 or pending[iss_rd] == 0; a WAW claim stalls until the earlier write is granted, with no same-cycle bypass.
REQ-029 haz_a = pending[rs] and rs != 0; haz_b = pending[rs2] and rs2 != 0; purely combinational.
REQ-030 A writeback to a register whose pending bit is clear SHALL be performed normally, leaving the bit clear.

Reset
REQ-031 While reset = 0: pending = 0, wb_wr = 0, wb_rd = 0, wb_data = 0, last-grant = load (ALU wins the first tie), alu_ready = ld_ready = iss_ready = 0.
REQ-032 Reset asserted mid-transfer discards the in-flight write; wb_wr drops to 0 asynchronously.
REQ-033 After reset deasserts, the first edge is a normal operating edge.

Verification
REQ-034 Issue rd=5, then ALU write rd=5, data 0x0000_00AA -> pending[5] goes 1 then 0; the cycle after the grant shows wb_wr=1, wb_rd=5, wb_data=0xAA.
REQ-035 FAIR=1, alu_valid and ld_valid held for 4 cycles (rd 3 and 4) -> grants alternate ALU, LD, ALU, LD starting with ALU.
REQ-036 FAIR=0, both valid for 3 cycles -> ld_ready=1 every cycle and alu_ready=0 throughout.
REQ-037 pending[7]=1, issue rd=7 -> iss_ready=0 until the write to 7 is granted, then iss_ready=1 the next cycle; haz_a=1 while rs=7 and pending.
REQ-038 ALU write rd=0, data 0xFFFF_FFFF -> alu_ready=1, wb_wr stays 0; issue rd=0 -> iss_ready=1, pending unchanged.
REQ-039 Issue rd=9 coinciding with a write grant to rd=9; then reset pulsed low mid-cycle -> pending[9]=1 after the edge; reset clears pending, wb_wr=0 with no clock edge.
